uart_tx_fifo_gen: RTL

Parametrised UART transmitter with an integrated TX FIFO. Data width, stop bits, parity mode and baud divisor are selected at runtime, and break generation is supported. It sits between the AXI-lite register block, which writes the FIFO, and the tx pin. Frames are sent back-to-back from the FIFO without per-byte handshaking from the controller.

---
 rtl/uart_tx_fifo_gen.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_gen.sv
// uart_tx_fifo_gen: UART transmitter with runtime frame format, break generation and an internal TX FIFO
module uart_tx_fifo_gen #(
  parameter int DIV_SIZE   = 16,
  parameter int DATA_MAX   = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                en_i,
  input  logic [3:0]          data_bits_i,
  input  logic                stop_bits_i,
  input  logic [2:0]          parity_mode_i,
  input  logic [DIV_SIZE-1:0] baud_div_i,
  input  logic                break_i,
  input  logic                flush_i,
  input  logic [DATA_MAX-1:0] wr_data_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  output logic [LVL_W-1:0]    level_o,
  output logic                empty_o,
  output logic                tx_o,
  output logic                busy_o,
  output logic                frame_done_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DMAX = 4'(DATA_MAX);
  localparam logic [LVL_W-1:0] FULL = LVL_W'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t state, state_d;
  logic [DATA_MAX-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic push, pop;
  logic [DIV_SIZE-1:0] cnt, div_q;
  logic [DATA_MAX-1:0] sh_q;
  logic [3:0] nbits_q, idx, nb_in;
  logic [2:0] par_q, pm_in;
  logic stop2_q, stop_idx, par_acc, mab, done_q, tick, par_bit;

  assign wr_ready_o = level != FULL;
  assign empty_o = level == '0;
  assign level_o = level;
  assign push = wr_valid_i & wr_ready_o & ~flush_i;
  assign tick = cnt == div_q;
  assign nb_in = data_bits_i < 4'd5 ? 4'd5 : data_bits_i > DMAX ? DMAX : data_bits_i;
  assign pm_in = parity_mode_i > 3'd4 ? 3'd0 : parity_mode_i;
  assign par_bit = par_q == 3'd1 ? ~par_acc : par_q == 3'd2 ? par_acc : par_q == 3'd3;
  assign busy_o = state != IDLE;
  assign frame_done_o = done_q;

  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= wr_data_i;

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) state <= IDLE;
    else state <= state_d;

  always_comb begin
    state_d = state;
    pop = 1'b0;
    tx_o = 1'b1;
    case (state)
      IDLE:
        if (break_i) state_d = BREAK;
        else if (en_i && !empty_o) begin
          state_d = START;
          pop = 1'b1;
        end
      START: begin
        tx_o = 1'b0;
        if (tick) state_d = DATA;
      end
      DATA: begin
        tx_o = sh_q[0];
        if (tick && idx == nbits_q - 4'd1) state_d = par_q == 3'd0 ? STOP : PARITY;
      end
      PARITY: begin
        tx_o = par_bit;
        if (tick) state_d = STOP;
      end
      STOP:
        if (tick && stop_idx == stop2_q) state_d = IDLE;
      BREAK: begin
        tx_o = mab;
        if (mab && tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame settings are re-latched on every IDLE cycle, so the values seen on the pop cycle stick for the frame
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      cnt      <= '0;
      div_q    <= '0;
      sh_q     <= '0;
      nbits_q  <= '0;
      idx      <= '0;
      par_q    <= '0;
      stop2_q  <= 1'b0;
      stop_idx <= 1'b0;
      par_acc  <= 1'b0;
      mab      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= state == STOP && state_d == IDLE;
      cnt <= (state == IDLE || (state == BREAK && !mab) || tick) ? '0 : cnt + 1'b1;
      if (state == IDLE) begin
        div_q    <= baud_div_i;
        sh_q     <= mem[rd_ptr];
        nbits_q  <= nb_in;
        par_q    <= pm_in;
        stop2_q  <= stop_bits_i;
        idx      <= '0;
        stop_idx <= 1'b0;
        par_acc  <= 1'b0;
        mab      <= 1'b0;
      end
      if (state == DATA && tick) begin
        sh_q    <= sh_q >> 1;
        par_acc <= par_acc ^ sh_q[0];
        idx     <= idx + 1'b1;
      end
      if (state == STOP && tick) stop_idx <= 1'b1;
      if (state == BREAK && !break_i) mab <= 1'b1;
    end
endmodule
